// File: rtl/dffrsnq_pipe.sv
// Purpose: DEPTH-stage valid/ready register pipeline with sync reset, sync set and a full-width scan chain.
// Latency: DEPTH cycles from input presentation to Q_VLD on an empty pipe; 1 word/cycle sustained.
// Backpressure: Q_RDY low stalls only the valid run at the output end; bubbles behind it keep collapsing.
module dffrsnq_pipe #(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] SET_VAL = {WIDTH{1'b1}}
) (
    input  logic                       CLK,
    input  logic                       RN,
    input  logic                       SETN,
    input  logic                       SE,
    input  logic                       SI,
    output logic                       SO,
    input  logic [WIDTH-1:0]           D,
    input  logic                       D_VLD,
    output logic                       D_RDY,
    output logic [WIDTH-1:0]           Q,
    output logic                       Q_VLD,
    input  logic                       Q_RDY,
    output logic [$clog2(DEPTH+1)-1:0] OCC
);

    localparam int OW = $clog2(DEPTH + 1);
    localparam int NB = WIDTH * DEPTH;

    if (WIDTH < 1 || WIDTH > 64 || DEPTH < 2 || DEPTH > 16) begin : g_param_chk
        $error("dffrsnq_pipe: WIDTH must be 1..64 and DEPTH 2..16");
    end

    logic [DEPTH-1:0][WIDTH-1:0] data_q;
    logic [DEPTH-1:0][WIDTH-1:0] data_d;
    logic [DEPTH-1:0]            vld_q;
    logic [DEPTH-1:0]            vld_d;
    logic [DEPTH-1:0]            adv;
    logic [OW-1:0]               occ_q;
    logic [OW-1:0]               occ_d;
    logic [NB-1:0]               chain;
    logic                        run_full;
    logic                        in_xfer;

    // Stage i can move only if some stage at or beyond it is empty, or the
    // output end is draining; scanning down from the output avoids a
    // self-referencing ripple through adv[].
    always_comb begin
        adv      = '0;
        run_full = 1'b1;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            run_full = run_full & vld_q[i];
            adv[i]   = Q_RDY | ~run_full;
        end
    end

    assign D_RDY   = adv[0] & ~SE & RN & SETN;
    assign in_xfer = D_VLD & D_RDY;
    assign chain   = data_q;

    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (!SETN) begin
            data_d = {DEPTH{SET_VAL}};
        end else if (SE) begin
            // data_q flattens with stage 0 bit 0 at the LSB, so one left
            // shift walks every bit along the chain towards SO.
            data_d = {chain[NB-2:0], SI};
        end else begin
            if (adv[0]) begin
                data_d[0] = D;
                vld_d[0]  = in_xfer;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (adv[i]) begin
                    data_d[i] = data_q[i-1];
                    vld_d[i]  = vld_q[i-1];
                end
            end
        end
    end

    always_comb begin
        occ_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_d = occ_d + OW'(vld_d[i]);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RN) begin
            data_q <= '0;
            vld_q  <= '0;
            occ_q  <= '0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
            occ_q  <= occ_d;
        end
    end

    assign Q     = data_q[DEPTH-1];
    assign Q_VLD = vld_q[DEPTH-1] & ~SE;
    assign SO    = data_q[DEPTH-1][WIDTH-1];
    assign OCC   = occ_q;

endmodule

// File: tb/tb_dffrsnq_pipe.sv
// Directed plus random bench for dffrsnq_pipe (WIDTH=8, DEPTH=4) against a
// word-position reference model: each held word carries its slot index.
module tb_dffrsnq_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rn, setn, se, si, so;
    logic [WIDTH-1:0] d, q;
    logic             d_vld, d_rdy, q_vld, q_rdy;
    logic [2:0]       occ;

    int n_chk  = 0;
    int n_fail = 0;

    logic [WIDTH-1:0] mq_dat[$];
    int               mq_pos[$];
    bit               sc_hist[$];

    dffrsnq_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK(clk), .RN(rn), .SETN(setn), .SE(se), .SI(si), .SO(so),
        .D(d), .D_VLD(d_vld), .D_RDY(d_rdy),
        .Q(q), .Q_VLD(q_vld), .Q_RDY(q_rdy), .OCC(occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, compare against the model's pre-edge view,
    // advance the model to match the edge, return 1 time unit after it.
    task automatic tick(input logic t_rn, input logic t_setn, input logic t_se, input logic t_si,
                        input logic t_dvld, input logic [WIDTH-1:0] t_d, input logic t_qrdy);
        logic exp_qvld, exp_drdy, normal;
        int   lim;
        rn = t_rn; setn = t_setn; se = t_se; si = t_si;
        d_vld = t_dvld; d = t_d; q_rdy = t_qrdy;
        #1;
        exp_qvld = !t_se && mq_pos.size() > 0 && mq_pos[0] == DEPTH - 1;
        check("q_vld", {63'd0, q_vld}, {63'd0, exp_qvld});
        check("occ", {61'd0, occ}, 64'(mq_pos.size()));
        if (exp_qvld) check("q_data", {56'd0, q}, {56'd0, mq_dat[0]});
        normal   = t_rn && t_setn && !t_se;
        exp_drdy = 1'b0;
        if (normal) begin
            if (exp_qvld && t_qrdy) begin
                void'(mq_dat.pop_front());
                void'(mq_pos.pop_front());
            end
            for (int k = 0; k < mq_pos.size(); k++) begin
                if (k == 0) lim = DEPTH - 1;
                else        lim = mq_pos[k-1] - 1;
                if (mq_pos[k] < lim) mq_pos[k] = mq_pos[k] + 1;
            end
            exp_drdy = (mq_pos.size() == 0) || (mq_pos[mq_pos.size()-1] > 0);
        end
        check("d_rdy", {63'd0, d_rdy}, {63'd0, exp_drdy});
        if (t_rn && t_setn && t_se) sc_hist.push_back(t_si);
        @(posedge clk);
        if (!t_rn) begin
            mq_dat.delete();
            mq_pos.delete();
        end else if (!t_setn) begin
            for (int k = 0; k < mq_dat.size(); k++) mq_dat[k] = 8'hFF;
        end else if (normal && t_dvld && exp_drdy) begin
            mq_dat.push_back(t_d);
            mq_pos.push_back(0);
        end
        #1;
    endtask

    task automatic idle(input logic t_qrdy);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, t_qrdy);
    endtask

    task automatic put(input logic [WIDTH-1:0] t_d, input logic t_qrdy);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, t_d, t_qrdy);
    endtask

    task automatic drain();
        for (int i = 0; i < 3 * DEPTH && mq_pos.size() > 0; i++) idle(1'b1);
        check("drain_occ", {61'd0, occ}, 64'd0);
    endtask

    initial begin
        int               lat;
        bit               found;
        logic [3:0]       pat;
        logic [WIDTH-1:0] tmp;
        int               n;

        rn = 1'b0; setn = 1'b1; se = 1'b0; si = 1'b0;
        d = '0; d_vld = 1'b0; q_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rn = 1'b1;
        #1;
        check("rst_q", {56'd0, q}, 64'd0);
        check("rst_q_vld", {63'd0, q_vld}, 64'd0);
        check("rst_occ", {61'd0, occ}, 64'd0);
        check("rst_so", {63'd0, so}, 64'd0);
        check("rst_d_rdy", {63'd0, d_rdy}, 64'd1);

        // Latency and back-to-back output.
        lat = 0; found = 1'b0;
        for (int t = 0; t < 12 && !found; t++) begin
            tick(1'b1, 1'b1, 1'b0, 1'b0, t < 3, 8'(8'h11 * (t + 1)), 1'b1);
            if (q_vld === 1'b1) begin
                found = 1'b1;
                lat   = t + 1;
            end
        end
        check("latency", 64'(lat), 64'(DEPTH));
        check("out0", {56'd0, q}, 64'h11);
        idle(1'b1);
        check("out1", {56'd0, q}, 64'h22);
        idle(1'b1);
        check("out2", {56'd0, q}, 64'h33);
        drain();

        // Full pipe: stall, then simultaneous in/out.
        for (int i = 0; i < 4; i++) put(8'(8'hA0 + i), 1'b0);
        check("full_occ", {61'd0, occ}, 64'd4);
        d_vld = 1'b1; d = 8'hA4; q_rdy = 1'b0;
        #1;
        check("full_stall_d_rdy", {63'd0, d_rdy}, 64'd0);
        q_rdy = 1'b1;
        #1;
        check("full_flow_d_rdy", {63'd0, d_rdy}, 64'd1);
        check("full_flow_q", {56'd0, q}, 64'hA0);
        put(8'hA4, 1'b1);
        check("full_flow_occ", {61'd0, occ}, 64'd4);
        check("full_flow_next_q", {56'd0, q}, 64'hA1);
        drain();

        // Bubble collapse under output stall.
        put(8'h01, 1'b0);
        idle(1'b0);
        idle(1'b0);
        put(8'h02, 1'b0);
        idle(1'b0);
        idle(1'b0);
        check("bubble_occ", {61'd0, occ}, 64'd2);
        check("bubble_q", {56'd0, q}, 64'h01);
        idle(1'b1);
        check("bubble_next_vld", {63'd0, q_vld}, 64'd1);
        check("bubble_next_q", {56'd0, q}, 64'h02);
        drain();

        // Synchronous set with two words held.
        put(8'h5A, 1'b0);
        put(8'h5B, 1'b0);
        repeat (3) idle(1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h77, 1'b1);
        check("set_occ", {61'd0, occ}, 64'd2);
        check("set_q", {56'd0, q}, 64'hFF);
        check("set_q_vld", {63'd0, q_vld}, 64'd1);
        drain();

        // Scan from reset: SO replays SI 32 cycles later.
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        sc_hist.delete();
        pat = 4'b1101;
        for (int j = 0; j < 64; j++) begin
            tick(1'b1, 1'b1, 1'b1, (j < 4) ? pat[j] : 1'($urandom_range(0, 1)),
                 1'b1, 8'hEE, 1'b1);
            if (j + 1 >= WIDTH * DEPTH) check("scan_so", {63'd0, so}, {63'd0, sc_hist[j + 1 - WIDTH * DEPTH]});
            else                        check("scan_so_zero", {63'd0, so}, 64'd0);
        end
        idle(1'b1);

        // Scan with words held: vld frozen, data replaced from the chain.
        put(8'hC3, 1'b0);
        put(8'h3C, 1'b0);
        repeat (3) idle(1'b0);
        sc_hist.delete();
        for (int j = 0; j < WIDTH * DEPTH; j++)
            tick(1'b1, 1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b1, 8'h99, 1'b1);
        check("scan_so_wrap", {63'd0, so}, {63'd0, sc_hist[0]});
        n = sc_hist.size();
        for (int k = 0; k < mq_dat.size(); k++) begin
            for (int b = 0; b < WIDTH; b++) tmp[b] = sc_hist[n - 1 - (mq_pos[k] * WIDTH + b)];
            mq_dat[k] = tmp;
        end
        drain();

        // Random traffic with occasional set and reset.
        for (int c = 0; c < 400; c++) begin
            tick(($urandom_range(0, 63) != 0), ($urandom_range(0, 31) != 0), 1'b0, 1'b0,
                 1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) != 0));
        end

        // Reset wins over set, scan and handshakes on a full pipe.
        for (int i = 0; i < 6; i++) put(8'($urandom), 1'b0);
        check("prerst_occ", {61'd0, occ}, 64'd4);
        tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h55, 1'b1);
        check("rst_prio_occ", {61'd0, occ}, 64'd0);
        check("rst_prio_q", {56'd0, q}, 64'd0);
        se = 1'b0;
        #1;
        check("rst_prio_q_vld", {63'd0, q_vld}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dffrsnq_pipe.md
DFFRSNQ_PIPE -- requirements
Module: dffrsnq_pipe

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the data width per stage (legal range 1..64).
REQ-002 Parameter DEPTH, default 4, SHALL set the number of register stages (legal range 2..16).
REQ-003 Parameter SET_VAL, default all-ones of WIDTH, SHALL be the value loaded by a set.
REQ-004 Port CLK, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port RN, input, 1 bit, SHALL be the reset: synchronous and active-low.
REQ-006 Port SETN, input, 1 bit, SHALL be the synchronous active-low set of all stage data.
REQ-007 Port SE, input, 1 bit, SHALL be the scan-enable.
REQ-008 Port SI, input, 1 bit, SHALL be the scan-in bit.
REQ-009 Port SO, output, 1 bit, SHALL be the scan-out bit, equal to bit WIDTH-1 of stage DEPTH-1.
REQ-010 Port D, input, WIDTH bits, SHALL be the upstream data.
REQ-011 Port D_VLD, input, 1 bit, SHALL be the upstream valid.
REQ-012 Port D_RDY, output, 1 bit, SHALL be the upstream ready.
REQ-013 Port Q, output, WIDTH bits, SHALL be stage DEPTH-1 data, driven directly from flops.
REQ-014 Port Q_VLD, output, 1 bit, SHALL be the downstream valid.
REQ-015 Port Q_RDY, input, 1 bit, SHALL be the downstream ready.
REQ-016 Port OCC, output, $clog2(DEPTH+1) bits, SHALL be the count of valid stages.

Function
REQ-017 Each stage i SHALL hold data[i] (WIDTH bits) and vld[i] (1 bit); stage 0 is the input end.
REQ-018 Control priority SHALL be RN low > SETN low > SE high > normal handshake.
REQ-019 Normal mode: stage DEPTH-1 advances when vld[DEPTH-1]=0 or Q_RDY=1; stage i<DEPTH-1 advances when vld[i]=0 or stage i+1 advances.
REQ-020 An advancing stage i>0 SHALL load data[i-1]/vld[i-1]; an advancing stage 0 SHALL load D and D_VLD&D_RDY.
REQ-021 A non-advancing stage SHALL hold data and vld unchanged.
REQ-022 Bubbles SHALL collapse: an invalid stage always accepts from its predecessor, even while the output is stalled.
REQ-023 D_RDY SHALL equal stage-0-advances and SE=0 and RN=1 and SETN=1.
REQ-024 Q_VLD SHALL equal vld[DEPTH-1] while SE=0, and 0 while SE=1.
REQ-025 A transfer out SHALL occur only on a cycle with Q_VLD=1 and Q_RDY=1; a transfer in only with D_VLD=1 and D_RDY=1.
REQ-026 Latency from input transfer to Q_VLD with an empty pipe and Q_RDY=1 SHALL be exactly DEPTH cycles; sustained throughput SHALL be 1 word/cycle.
REQ-027 Data order SHALL be preserved; no word is dropped or duplicated.
REQ-028 OCC SHALL equal the popcount of vld[] as registered after each edge, range 0..DEPTH.
REQ-029 Full (OCC=DEPTH) with Q_RDY=0 SHALL force D_RDY=0; full with Q_RDY=1 SHALL give D_RDY=1 (simultaneous in/out, OCC unchanged).
REQ-030 SETN low (RN high) SHALL load SET_VAL into every data[i] and leave vld[] unchanged; no transfers occur that cycle.
REQ-031 SE high (RN, SETN high) SHALL shift the WIDTH*DEPTH data bits as one chain: SI into data[0][0], bit b into b+1 within a stage, data[i][WIDTH-1] into data[i+1][0]; vld[] frozen.
REQ-032 Returning SE to 0 SHALL resume normal mode with the shifted data and the frozen vld[].

Reset
REQ-033 RN sampled low on a rising CLK edge SHALL clear all data[] to 0 and all vld[] to 0, overriding SETN, SE and handshakes.
REQ-034 After reset: Q=0, Q_VLD=0, OCC=0, SO=0; D_RDY=1 from the first cycle with RN, SETN high and SE low.
REQ-035 Reset asserted mid-transfer SHALL discard all in-flight words; no output transfer occurs on the reset edge.
REQ-036 Before the first active RN edge, outputs are undefined; no asynchronous path from RN to any flop SHALL exist.

Verification
REQ-037 DEPTH=4, WIDTH=8: reset, then D=0x11,0x22,0x33 on consecutive cycles, Q_RDY=1 -> Q_VLD first high 4 cycles after 0x11 accepted, Q=0x11,0x22,0x33 consecutive.
REQ-038 Fill with 0xA0..0xA3, Q_RDY=0 -> OCC=4, D_RDY=0; then Q_RDY=1 with D_VLD=1 D=0xA4 -> 0xA0 out and 0xA4 in same cycle, OCC stays 4.
REQ-039 Insert 0x01, idle 2 cycles, insert 0x02 with Q_RDY=0 -> bubbles collapse, OCC=2, vld[3:2]=11.
REQ-040 Pipe holding 2 words, SETN low 1 cycle -> all data=0xFF, OCC=2 unchanged, Q_VLD unchanged.
REQ-041 After reset, SE=1 for 32 cycles with SI pattern 1,0,1,1,... -> SO replays SI delayed 32 cycles; Q_VLD=0, D_RDY=0 throughout.
REQ-042 Pipe full, RN low with SETN low and SE high simultaneously -> next edge: all data 0, OCC=0, Q_VLD=0.
